// File: rtl/barrel_shifter_pkg.sv
// Shared op encoding and helpers for the pipelined barrel shifter.
// Optional flags (out_zero/out_carry) are enabled with BARREL_SHIFTER_FLAGS_EN.
package barrel_shifter_pkg;

    typedef logic [2:0] bsh_op_t;

    localparam bsh_op_t OP_SLL = 3'b000;
    localparam bsh_op_t OP_SRL = 3'b001;
    localparam bsh_op_t OP_SRA = 3'b010;
    localparam bsh_op_t OP_ROL = 3'b011;
    localparam bsh_op_t OP_ROR = 3'b100;

    function automatic logic is_right(bsh_op_t op);
        return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

    function automatic logic is_rot(bsh_op_t op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

    function automatic logic is_resv(bsh_op_t op);
        return op > OP_ROR;
    endfunction

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Operand/result handshake bundle of the pipelined barrel shifter.
// Flag signals exist only when BARREL_SHIFTER_FLAGS_EN is defined.
interface barrel_shifter_pipe_if
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    bsh_op_t          in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
`ifdef BARREL_SHIFTER_FLAGS_EN
    logic             out_zero;
    logic             out_carry;
`endif

    modport master (
        output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
`ifdef BARREL_SHIFTER_FLAGS_EN
        , input out_zero, out_carry
`endif
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
`ifdef BARREL_SHIFTER_FLAGS_EN
        , output out_zero, out_carry
`endif
    );

endinterface

// File: rtl/bsh_stage.sv
// One barrel-shifter pipeline stage: conditional shift by DIST plus
// its valid/data/op/amt/sideband register and advance logic.
module bsh_stage
    import barrel_shifter_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int TAG_W = 4,
    parameter  int DIST  = 1,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  bsh_op_t          up_op,
    input  logic [SHW-1:0]   up_amt,
    input  logic [TAG_W-1:0] up_tag,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data,
    output bsh_op_t          dn_op,
    output logic [SHW-1:0]   dn_amt,
    output logic [TAG_W-1:0] dn_tag
);
    localparam int K = $clog2(DIST);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    bsh_op_t          op_q, op_d;
    logic [SHW-1:0]   amt_q, amt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] shd;
    logic             load;

    always_comb begin
        shd = up_data;
        if (up_amt[K]) begin
            unique case (up_op)
                OP_SLL:  shd = up_data << DIST;
                OP_SRL:  shd = up_data >> DIST;
                OP_SRA:  shd = $signed(up_data) >>> DIST;
                OP_ROL:  shd = (up_data << DIST) | (up_data >> (WIDTH - DIST));
                OP_ROR:  shd = (up_data >> DIST) | (up_data << (WIDTH - DIST));
                default: shd = up_data;
            endcase
        end
    end

    // Accept when empty or when the held word leaves this cycle.
    assign up_ready = !valid_q || dn_ready;
    assign load     = up_ready && up_valid;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        op_d    = op_q;
        amt_d   = amt_q;
        tag_d   = tag_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (up_ready) begin
            valid_d = up_valid;
        end
        if (load) begin
            data_d = shd;
            op_d   = up_op;
            amt_d  = up_amt;
            tag_d  = up_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= OP_SLL;
            amt_q   <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            tag_q   <= tag_d;
        end
    end

    assign dn_valid = valid_q;
    assign dn_data  = data_q;
    assign dn_op    = op_q;
    assign dn_amt   = amt_q;
    assign dn_tag   = tag_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter, one shift level per stage, valid/ready on both sides.
// Define BARREL_SHIFTER_FLAGS_EN to add out_zero/out_carry.
module barrel_shifter_pipe
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    barrel_shifter_pipe_if.slave bus
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int NSTG = SHW;
`ifdef BARREL_SHIFTER_FLAGS_EN
    localparam int SB_W = TAG_W + 1;
`else
    localparam int SB_W = TAG_W;
`endif

    logic             s_valid [NSTG+1];
    logic             s_ready [NSTG+1];
    logic [WIDTH-1:0] s_data  [NSTG+1];
    bsh_op_t          s_op    [NSTG+1];
    logic [SHW-1:0]   s_amt   [NSTG+1];
    logic [SB_W-1:0]  s_sb    [NSTG+1];

    // Reserved ops pass the word through by forcing a zero shift.
    assign s_valid[0] = bus.in_valid;
    assign s_data[0]  = bus.in_data;
    assign s_op[0]    = bus.in_op;
    assign s_amt[0]   = is_resv(bus.in_op) ? '0 : bus.in_amt;

`ifdef BARREL_SHIFTER_FLAGS_EN
    logic           in_carry;
    logic [SHW-1:0] r_idx;
    logic [SHW-1:0] l_idx;

    assign r_idx = s_amt[0] - 1'b1;
    assign l_idx = SHW'(WIDTH - int'(s_amt[0]));

    // Last bit shifted out, carried alongside the tag.
    always_comb begin
        in_carry = 1'b0;
        if (!is_rot(s_op[0]) && s_amt[0] != '0) begin
            in_carry = is_right(s_op[0]) ? bus.in_data[r_idx]
                                         : bus.in_data[l_idx];
        end
    end

    assign s_sb[0] = {in_carry, bus.in_tag};
`else
    assign s_sb[0] = bus.in_tag;
`endif

    assign bus.in_ready  = s_ready[0] && !flush;
    assign s_ready[NSTG] = bus.out_ready;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        bsh_stage #(
            .WIDTH (WIDTH),
            .TAG_W (SB_W),
            .DIST  (1 << k)
        ) u_stg (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (s_valid[k]),
            .up_ready (s_ready[k]),
            .up_data  (s_data[k]),
            .up_op    (s_op[k]),
            .up_amt   (s_amt[k]),
            .up_tag   (s_sb[k]),
            .dn_valid (s_valid[k+1]),
            .dn_ready (s_ready[k+1]),
            .dn_data  (s_data[k+1]),
            .dn_op    (s_op[k+1]),
            .dn_amt   (s_amt[k+1]),
            .dn_tag   (s_sb[k+1])
        );
    end

    assign bus.out_valid = s_valid[NSTG];
    assign bus.out_data  = s_data[NSTG];
    assign bus.out_tag   = s_sb[NSTG][TAG_W-1:0];

`ifdef BARREL_SHIFTER_FLAGS_EN
    // Qualified by valid so both flags read 0 out of reset.
    assign bus.out_zero  = bus.out_valid && (bus.out_data == '0);
    assign bus.out_carry = s_sb[NSTG][TAG_W];
`endif

    logic unused_tail;
    assign unused_tail = ^{s_op[NSTG], s_amt[NSTG]};

endmodule
